// File: rtl/ones_burst_generator_if.sv
// Start/Count/Gap request bundle and Out/Busy/Done status of the ones burst generator.
// GEN_ABORT_EN adds the Abort request line.
interface ones_burst_generator_if #(
    parameter int CNT_W = 4,
    parameter int GAP_W = 4
);
    logic             Start;
    logic [CNT_W-1:0] Count;
    logic [GAP_W-1:0] Gap;
    logic             Out;
    logic             Busy;
    logic             Done;
`ifdef GEN_ABORT_EN
    logic             Abort;

    modport master (output Start, Count, Gap, Abort, input Out, Busy, Done);
    modport slave  (input Start, Count, Gap, Abort, output Out, Busy, Done);
`else
    modport master (output Start, Count, Gap, input Out, Busy, Done);
    modport slave  (input Start, Count, Gap, output Out, Busy, Done);
`endif
endinterface

// File: rtl/ones_burst_generator.sv
// Serial '1' burst source: Count single-cycle pulses separated by Gap zero cycles, then Done.
// Optional feature macro: GEN_ABORT_EN (adds Abort, which drops an active burst to IDLE).
module ones_burst_generator #(
    parameter int CNT_W = 4,
    parameter int GAP_W = 4
) (
    input  logic                     Clk,
    input  logic                     Rst,
    ones_burst_generator_if.slave    bus
);
    typedef enum logic [1:0] {IDLE, EMIT, GAP, DONE} state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [GAP_W-1:0] GAP_ONE = GAP_W'(1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] rem, rem_nxt;
    logic [GAP_W-1:0] gap_ld, gap_ld_nxt;
    logic [GAP_W-1:0] gap_cnt, gap_cnt_nxt;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state   <= IDLE;
            rem     <= '0;
            gap_ld  <= '0;
            gap_cnt <= '0;
        end else begin
            state   <= state_nxt;
            rem     <= rem_nxt;
            gap_ld  <= gap_ld_nxt;
            gap_cnt <= gap_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        rem_nxt     = rem;
        gap_ld_nxt  = gap_ld;
        gap_cnt_nxt = gap_cnt;
        case (state)
            IDLE: begin
                if (bus.Start) begin
                    gap_ld_nxt = bus.Gap;
                    if (bus.Count == '0) begin
                        state_nxt = DONE;
                        rem_nxt   = '0;
                    end else begin
                        state_nxt = EMIT;
                        rem_nxt   = bus.Count - CNT_ONE;
                    end
                end
            end
            EMIT: begin
                if (rem == '0) begin
                    state_nxt = DONE;
                end else if (gap_ld == '0) begin
                    state_nxt = EMIT;
                    rem_nxt   = rem - CNT_ONE;
                end else begin
                    state_nxt   = GAP;
                    gap_cnt_nxt = gap_ld - GAP_ONE;
                end
            end
            GAP: begin
                if (gap_cnt == '0) begin
                    state_nxt = EMIT;
                    // rem is nonzero whenever GAP is entered; the guard keeps it from wrapping
                    if (rem != '0) rem_nxt = rem - CNT_ONE;
                end else begin
                    gap_cnt_nxt = gap_cnt - GAP_ONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
`ifdef GEN_ABORT_EN
        if (bus.Abort && (state == EMIT || state == GAP)) begin
            state_nxt   = IDLE;
            rem_nxt     = '0;
            gap_cnt_nxt = '0;
        end
`endif
    end

    always_comb begin
        bus.Out  = 1'b0;
        bus.Busy = 1'b0;
        bus.Done = 1'b0;
        case (state)
            EMIT: begin
                bus.Out  = 1'b1;
                bus.Busy = 1'b1;
            end
            GAP:  bus.Busy = 1'b1;
            DONE: bus.Done = 1'b1;
            default: ;
        endcase
    end
endmodule
